// File: rtl/bank_queue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : bank_queue_ctrl_if
// Brief    : Sensor/teller inputs and display-stage outputs of bank_queue_ctrl
// Revision : 1.0 - initial release
// ============================================================================
interface bank_queue_ctrl_if;
  logic       front_sensor;
  logic       back_sensor;
  logic [1:0] tcount;
  logic [3:0] pcount;
  logic [4:0] wtime;
  logic       full;
  logic       empty;

  modport master (
    output front_sensor, back_sensor, tcount,
    input  pcount, wtime, full, empty
  );

  modport slave (
    input  front_sensor, back_sensor, tcount,
    output pcount, wtime, full, empty
  );
endinterface
`default_nettype wire

// File: rtl/bank_queue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bank_queue_ctrl
// Brief    : Queue occupancy counter with waiting-time estimate and lamps.
//            Optional macro SENSOR_SYNC_EN adds 2-flop sensor synchronizers.
// Revision : 1.0 - initial release
// ============================================================================
module bank_queue_ctrl #(
  parameter int MAX_PEOPLE   = 7,
  parameter int SERVICE_TIME = 3
) (
  input  wire              clk,
  input  wire              rst,
  bank_queue_ctrl_if.slave bus
);

  localparam logic [3:0] c_MAX = 4'(MAX_PEOPLE);
  localparam logic [6:0] c_SVC = 7'(SERVICE_TIME);

  logic       w_front_s;
  logic       w_back_s;
  logic       r_front_prev;
  logic       r_back_prev;
  logic       w_enter;
  logic       w_leave;
  logic [3:0] r_pcount;
  logic [3:0] w_pcount_nxt;
  logic [4:0] r_wtime;
  logic       r_full;
  logic       r_empty;
  logic [6:0] w_t;
  logic [6:0] w_num;
  logic [4:0] w_wtime_nxt;

`ifdef SENSOR_SYNC_EN
  logic [1:0] r_front_sync;
  logic [1:0] r_back_sync;

  // Reset to 1 so a beam broken across reset release looks already-seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_front_sync <= 2'b11;
      r_back_sync  <= 2'b11;
    end else begin
      r_front_sync <= {r_front_sync[0], bus.front_sensor};
      r_back_sync  <= {r_back_sync[0], bus.back_sensor};
    end
  end

  assign w_front_s = r_front_sync[1];
  assign w_back_s  = r_back_sync[1];
`else
  assign w_front_s = bus.front_sensor;
  assign w_back_s  = bus.back_sensor;
`endif

  assign w_enter = w_front_s & ~r_front_prev;
  assign w_leave = w_back_s & ~r_back_prev;

  always_comb begin
    w_pcount_nxt = r_pcount;
    if (w_enter && !w_leave) begin
      if (r_pcount < c_MAX)
        w_pcount_nxt = r_pcount + 4'd1;
    end else if (w_leave && !w_enter) begin
      if (r_pcount != 4'd0)
        w_pcount_nxt = r_pcount - 4'd1;
    end else if (w_enter && w_leave) begin
      // Simultaneous events cancel unless one of them is impossible.
      if (r_pcount == 4'd0)
        w_pcount_nxt = 4'd1;
      else if (r_pcount == c_MAX)
        w_pcount_nxt = c_MAX - 4'd1;
    end
  end

  // Teller count of 0 is treated as a single teller.
  assign w_t   = (bus.tcount == 2'd0) ? 7'd1 : {5'd0, bus.tcount};
  assign w_num = c_SVC * ({3'd0, r_pcount} + w_t - 7'd1);

  always_comb begin
    w_wtime_nxt = 5'd0;
    if (r_pcount != 4'd0)
      w_wtime_nxt = 5'(w_num / w_t);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_front_prev <= 1'b1;
      r_back_prev  <= 1'b1;
      r_pcount     <= 4'd0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_wtime      <= 5'd0;
    end else begin
      r_front_prev <= w_front_s;
      r_back_prev  <= w_back_s;
      r_pcount     <= w_pcount_nxt;
      r_full       <= (w_pcount_nxt == c_MAX);
      r_empty      <= (w_pcount_nxt == 4'd0);
      r_wtime      <= w_wtime_nxt;
    end
  end

  assign bus.pcount = r_pcount;
  assign bus.wtime  = r_wtime;
  assign bus.full   = r_full;
  assign bus.empty  = r_empty;

endmodule
`default_nettype wire

// File: tb/tb_bank_queue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bank_queue_ctrl
// Brief    : Directed self-checking bench for bank_queue_ctrl
// Revision : 1.0 - initial release
// ============================================================================
module tb_bank_queue_ctrl;

  localparam int c_MAX  = 7;
  localparam int c_SVC  = 3;
`ifdef SENSOR_SYNC_EN
  localparam int c_PLAT = 3;
`else
  localparam int c_PLAT = 1;
`endif

  typedef struct {
    logic [3:0] pc;
    logic       full;
    logic       empty;
    logic [4:0] wt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bank_queue_ctrl_if bus ();

  bank_queue_ctrl #(.MAX_PEOPLE(c_MAX), .SERVICE_TIME(c_SVC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   mpc      = 0;
  exp_t sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_wt(input int pc, input int tc);
    int t;
    t = (tc == 0) ? 1 : tc;
    return (pc == 0) ? 0 : ((c_SVC * (pc + t - 1)) / t) % 32;
  endfunction

  function automatic int model_next(input int pc, input bit en, input bit lv);
    if (en && !lv) return (pc < c_MAX) ? pc + 1 : pc;
    if (lv && !en) return (pc > 0) ? pc - 1 : pc;
    if (en && lv) begin
      if (pc == 0) return 1;
      if (pc == c_MAX) return c_MAX - 1;
    end
    return pc;
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    bus.front_sensor = 1'b0;
    bus.back_sensor  = 1'b0;
    bus.tcount       = 2'd1;
    mpc = 0;
    tick(); tick();
    rst = 1'b0;
    repeat (4) tick();
  endtask

  // Raise the selected beams for `hold` cycles, then lower them.
  task automatic pulse(input bit f, input bit b, input int hold);
    exp_t e;
    mpc     = model_next(mpc, f, b);
    e.pc    = 4'(mpc);
    e.full  = (mpc == c_MAX);
    e.empty = (mpc == 0);
    e.wt    = 5'(model_wt(mpc, int'(bus.tcount)));
    sb.push_back(e);
    bus.front_sensor = f;
    bus.back_sensor  = b;
    repeat (c_PLAT) tick();
    e = sb.pop_front();
    chk("pcount", int'(bus.pcount), int'(e.pc));
    chk("full",   int'(bus.full),   int'(e.full));
    chk("empty",  int'(bus.empty),  int'(e.empty));
    tick();
    chk("wtime",  int'(bus.wtime),  int'(e.wt));
    if (hold > c_PLAT + 1) repeat (hold - c_PLAT - 1) tick();
    chk("held_once", int'(bus.pcount), int'(e.pc));
    bus.front_sensor = 1'b0;
    bus.back_sensor  = 1'b0;
    repeat (c_PLAT + 2) tick();
  endtask

  initial begin
    bus.front_sensor = 1'b0;
    bus.back_sensor  = 1'b0;
    bus.tcount       = 2'd1;
    apply_reset();
    chk("rst_pcount", int'(bus.pcount), 0);
    chk("rst_wtime",  int'(bus.wtime),  0);
    chk("rst_full",   int'(bus.full),   0);
    chk("rst_empty",  int'(bus.empty),  1);

    // Single held entry counts once
    pulse(1'b1, 1'b0, 5);
    chk("t1_wtime", int'(bus.wtime), 3);

    // tcount 0 behaves as one teller
    bus.tcount = 2'd0;
    tick();
    chk("t0_wtime", int'(bus.wtime), 3);
    bus.tcount = 2'd1;

    // Fill to capacity, then overflow attempt
    apply_reset();
    for (int i = 0; i < 7; i++) pulse(1'b1, 1'b0, 2);
    chk("t2_pcount", int'(bus.pcount), 7);
    chk("t2_full",   int'(bus.full),   1);
    chk("t2_wtime",  int'(bus.wtime),  21);
    pulse(1'b1, 1'b0, 2);
    chk("t2_ovf", int'(bus.pcount), 7);

    // Waiting time versus teller count
    apply_reset();
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, 2);
    chk("t3_w1", int'(bus.wtime), 15);
    bus.tcount = 2'd2;
    tick();
    chk("t3_w2", int'(bus.wtime), 9);
    bus.tcount = 2'd3;
    tick();
    chk("t3_w3", int'(bus.wtime), 7);
    bus.tcount = 2'd1;
    tick();

    // Exit when empty is ignored
    apply_reset();
    pulse(1'b0, 1'b1, 2);
    chk("t4_empty", int'(bus.empty), 1);

    // Simultaneous edges at mid, empty and full
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 2);
    pulse(1'b1, 1'b1, 2);
    chk("t5_mid", int'(bus.pcount), 3);
    apply_reset();
    pulse(1'b1, 1'b1, 2);
    chk("t5_empty", int'(bus.pcount), 1);
    for (int i = 0; i < 6; i++) pulse(1'b1, 1'b0, 2);
    chk("t5_fullpre", int'(bus.pcount), 7);
    pulse(1'b1, 1'b1, 2);
    chk("t5_full", int'(bus.pcount), 6);

    // Asynchronous reset mid-cycle with entry beam held high
    apply_reset();
    for (int i = 0; i < 4; i++) pulse(1'b1, 1'b0, 2);
    chk("t6_pre", int'(bus.pcount), 4);
    bus.front_sensor = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("t6_async_pcount", int'(bus.pcount), 0);
    chk("t6_async_wtime",  int'(bus.wtime),  0);
    chk("t6_async_empty",  int'(bus.empty),  1);
    mpc = 0;
    tick(); tick();
    #3 rst = 1'b0;
    repeat (6) tick();
    chk("t6_nocount", int'(bus.pcount), 0);
    chk("t6_nowtime", int'(bus.wtime),  0);
    bus.front_sensor = 1'b0;
    repeat (c_PLAT + 2) tick();
    pulse(1'b1, 1'b0, 2);
    chk("t6_recount", int'(bus.pcount), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
